uart_tx: RTL and testbench

Serial 8-bit UART transmitter for the UART0 peripheral, the transmit-side counterpart of the UART0 receiver. The block buffers bytes written by the bus-side register logic in a small FIFO. It serialises them LSB-first as start/data/stop frames at a programmable bit period. When the queue drains, it raises the UART0TX interrupt source (trap code 17).

---
 rtl/uart_tx.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, LSB-first 8N1 frames at a programmable bit period.
// Define LEXINGTON_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        irq
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

`ifdef LEXINGTON_UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]           mem [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 push, pop;
    logic                 fifo_empty;
    logic [7:0]           head;

    // Transmit datapath
    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] timer_q, timer_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 irq_q, irq_d;
    logic                 bit_end;
`ifdef LEXINGTON_UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign head       = mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign wr_ready   = (count_q != FullCount);
    assign push       = wr_en && wr_ready;
    assign bit_end    = (timer_q == '0);

    assign tx         = tx_q;
    assign busy       = (state_q != StIdle);
    assign fifo_count = count_q;
    assign irq        = irq_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        irq_d     = 1'b0;
        pop       = 1'b0;
`ifdef LEXINGTON_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (!bit_end) begin
            timer_d = timer_q - DIV_WIDTH'(1);
        end

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = StStart;
                    tx_d    = 1'b0;
                    timer_d = baud_div;
`ifdef LEXINGTON_UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    tx_d      = shift_q[0];
                    timer_d   = baud_div;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    timer_d = baud_div;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
`ifdef LEXINGTON_UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // tx is registered, so present the bit that becomes bit 0 after the shift
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef LEXINGTON_UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                    timer_d = baud_div;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next frame without an idle bit
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = StStart;
                        tx_d    = 1'b0;
                        timer_d = baud_div;
`ifdef LEXINGTON_UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        irq_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b0;
`ifdef LEXINGTON_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
`ifdef LEXINGTON_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Storage needs no reset; stale entries are unreachable once the count is cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized checks of uart_tx against a frame-timeline model.
// Builds with or without LEXINGTON_UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int unsigned Depth = 8;
`ifdef LEXINGTON_UART_TX_PARITY_EN
    localparam int NBits = 11;
`else
    localparam int NBits = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = '0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready, tx, busy, irq;
    logic [3:0]  fifo_count;

    uart_tx #(.FIFO_DEPTH(Depth), .DIV_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: queue of waiting bytes plus the edge at which the current frame began
    logic [7:0] m_q[$];
    bit         m_active;
    int         m_start;
    logic [7:0] m_byte;
    int         cyc;
    int         irq_seen, peak_count, dut_acc;

    typedef struct packed {
        logic [15:0] bd;
        logic [3:0]  n;
        logic [79:0] bytes;
        logic [3:0]  exp_accepted;
        logic [3:0]  exp_peak;
        logic [3:0]  exp_irqs;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic exp_tx(input int off, input int bd, input logic [7:0] b);
        int idx = off / (bd + 1);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NBits == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 0;
        m_start  = 0;
        m_byte   = '0;
        cyc      = 0;
    endtask

    task automatic scen_reset();
        irq_seen   = 0;
        peak_count = 0;
        dut_acc    = 0;
    endtask

    // One clock: drive inputs, advance the model by one edge, compare all outputs
    task automatic step(input logic we, input logic [7:0] d);
        int   bd = int'(baud_div);
        int   frame = NBits * (bd + 1);
        logic rdy_before = wr_ready;
        bit   done, do_push, do_pop, exp_irq;
        logic exp_t;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        #1;
        cyc++;
        done    = m_active && (cyc - m_start == frame);
        do_push = we && (m_q.size() < Depth);
        do_pop  = (!m_active || done) && (m_q.size() > 0);
        exp_irq = done && !do_pop;
        if (done) m_active = 0;
        if (do_pop) begin
            m_byte   = m_q.pop_front();
            m_start  = cyc;
            m_active = 1;
        end
        if (do_push) m_q.push_back(d);
        exp_t = m_active ? exp_tx(cyc - m_start, bd, m_byte) : 1'b1;
        check("tx", 32'(tx), 32'(exp_t));
        check("busy", 32'(busy), 32'(m_active));
        check("irq", 32'(irq), 32'(exp_irq));
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("wr_ready", 32'(wr_ready), 32'(m_q.size() < Depth));
        if (irq === 1'b1) irq_seen++;
        if (we && rdy_before === 1'b1) dut_acc++;
        if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int left = budget;
        while ((m_active || m_q.size() > 0) && left > 0) begin
            step(1'b0, 8'h00);
            left--;
        end
        repeat (3) step(1'b0, 8'h00);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        vec_t v;
        model_reset();
        scen_reset();

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        repeat (20) step(1'b0, 8'h00);

        // Scenario table: bit period, bytes written on consecutive cycles, expected summary
        vecs.push_back('{bd: 16'd3, n: 4'd1, bytes: 80'h0000000000000000_00A5,
                         exp_accepted: 4'd1, exp_peak: 4'd1, exp_irqs: 4'd1});
        vecs.push_back('{bd: 16'd1, n: 4'd3, bytes: 80'h00000000000000_55FF00,
                         exp_accepted: 4'd3, exp_peak: 4'd2, exp_irqs: 4'd1});
        vecs.push_back('{bd: 16'd9, n: 4'd10, bytes: 80'hEE_DD_CC_BB_AA_99_88_77_66_11,
                         exp_accepted: 4'd9, exp_peak: 4'd8, exp_irqs: 4'd1});
        vecs.push_back('{bd: 16'd0, n: 4'd2, bytes: 80'h000000000000000_0180,
                         exp_accepted: 4'd2, exp_peak: 4'd1, exp_irqs: 4'd1});
`ifdef LEXINGTON_UART_TX_PARITY_EN
        vecs.push_back('{bd: 16'd0, n: 4'd1, bytes: 80'h0000000000000000_0007,
                         exp_accepted: 4'd1, exp_peak: 4'd1, exp_irqs: 4'd1});
        vecs.push_back('{bd: 16'd0, n: 4'd1, bytes: 80'h0000000000000000_0003,
                         exp_accepted: 4'd1, exp_peak: 4'd1, exp_irqs: 4'd1});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            baud_div = v.bd;
            scen_reset();
            for (int k = 0; k < int'(v.n); k++) step(1'b1, v.bytes[8*k +: 8]);
            drain(3000);
            check($sformatf("vec%0d_accepted", i), 32'(dut_acc), 32'(v.exp_accepted));
            check($sformatf("vec%0d_peak", i), 32'(peak_count), 32'(v.exp_peak));
            check($sformatf("vec%0d_irqs", i), 32'(irq_seen), 32'(v.exp_irqs));
        end

        // Async reset during data bit 2 of 0x0F, with a second byte still queued
        baud_div = 16'd3;
        scen_reset();
        step(1'b1, 8'h0F);
        step(1'b1, 8'h11);
        repeat (12) step(1'b0, 8'h00);
        #3;
        rst = 1'b1;
        #1;
        check("arst_tx", 32'(tx), 32'd1);
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(wr_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("arst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        model_reset();
        scen_reset();
        step(1'b1, 8'h3C);
        drain(3000);
        check("arst_irqs", 32'(irq_seen), 32'd1);
        check("arst_accepted", 32'(dut_acc), 32'd1);

        // Randomized traffic; baud_div only changes while the transmitter is idle
        for (int it = 0; it < 6; it++) begin
            baud_div = 16'($urandom_range(0, 3));
            scen_reset();
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(0, 3) == 0, 8'($urandom));
            end
            drain(5000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
